// File: rtl/multicycle_control_unit.sv
// Multicycle RV32I(+M) control FSM: sequences fetch/decode/execute/memory/writeback,
// handshakes with instruction/data memory and an optional MDU, and traps on faults.
module multicycle_control_unit #(
    parameter int MEXT_EN     = 0,
    parameter int MEM_TIMEOUT = 255
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] OpCode,
    input  logic [2:0] Funct3,
    input  logic [6:0] Funct7,
    input  logic       imem_ready,
    input  logic       dmem_ready,
    input  logic       mdu_done,
    output logic       imem_req,
    output logic       dmem_req,
    output logic       IRWr,
    output logic       PCWr,
    output logic       mdu_start,
    output logic       RUWr,
    output logic [4:0] ALUOp,
    output logic [2:0] ImmSrc,
    output logic       ALUASrc,
    output logic       ALUBSrc,
    output logic       DMWr,
    output logic [2:0] DMCtrl,
    output logic [4:0] BrOp,
    output logic [1:0] RUDataWrSrc,
    output logic       trap,
    output logic [1:0] trap_cause,
    output logic [2:0] state
);

    typedef enum logic [2:0] {
        S_FETCH    = 3'd0,
        S_DECODE   = 3'd1,
        S_EXEC     = 3'd2,
        S_MEM      = 3'd3,
        S_WB       = 3'd4,
        S_MDU_WAIT = 3'd5,
        S_TRAP     = 3'd6,
        S_BAD      = 3'd7
    } state_t;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    localparam logic [1:0] CAUSE_ILLEGAL = 2'b01;
    localparam logic [1:0] CAUSE_TIMEOUT = 2'b10;

    // Counter is wide enough to hold MEM_TIMEOUT; LAST is the final waiting cycle.
    localparam int CNT_W = $clog2(MEM_TIMEOUT + 2);
    localparam logic [CNT_W-1:0] LAST = (MEM_TIMEOUT == 0) ? '0 : CNT_W'(MEM_TIMEOUT - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       cause_q, cause_d;
    logic             run_q;

    logic is_r, is_i, is_load, is_store, is_branch, is_jal, is_jalr, is_lui, is_auipc;
    logic is_mext, legal_op, illegal, timeout_hit;

    assign is_r      = (OpCode == OP_R);
    assign is_i      = (OpCode == OP_I);
    assign is_load   = (OpCode == OP_LOAD);
    assign is_store  = (OpCode == OP_STORE);
    assign is_branch = (OpCode == OP_BRANCH);
    assign is_jal    = (OpCode == OP_JAL);
    assign is_jalr   = (OpCode == OP_JALR);
    assign is_lui    = (OpCode == OP_LUI);
    assign is_auipc  = (OpCode == OP_AUIPC);

    assign is_mext  = (MEXT_EN != 0) && is_r && (Funct7 == 7'b0000001);
    assign legal_op = is_r | is_i | is_load | is_store | is_branch |
                      is_jal | is_jalr | is_lui | is_auipc;
    assign illegal  = !legal_op ||
                      (is_r && !(Funct7 == 7'b0000000 || Funct7 == 7'b0100000 || is_mext));

    assign timeout_hit = (MEM_TIMEOUT != 0) && (cnt_q == LAST);

    // run_q holds the FSM idle until the first clock edge after reset release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_FETCH;
            cnt_q   <= '0;
            cause_q <= 2'b00;
            run_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            cause_q <= cause_d;
            run_q   <= 1'b1;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        cause_d   = cause_q;
        imem_req  = 1'b0;
        dmem_req  = 1'b0;
        IRWr      = 1'b0;
        PCWr      = 1'b0;
        RUWr      = 1'b0;
        DMWr      = 1'b0;
        mdu_start = 1'b0;
        if (run_q) begin
            case (state_q)
                S_FETCH: begin
                    imem_req = 1'b1;
                    if (imem_ready) begin
                        IRWr    = 1'b1;
                        state_d = S_DECODE;
                    end else if (timeout_hit) begin
                        state_d = S_TRAP;
                        cause_d = CAUSE_TIMEOUT;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                S_DECODE: begin
                    if (illegal) begin
                        state_d = S_TRAP;
                        cause_d = CAUSE_ILLEGAL;
                    end else if (is_mext) begin
                        mdu_start = 1'b1;
                        state_d   = S_MDU_WAIT;
                    end else begin
                        state_d = S_EXEC;
                    end
                end
                S_EXEC: begin
                    if (is_load || is_store) begin
                        state_d = S_MEM;
                    end else if (is_branch) begin
                        PCWr    = 1'b1;
                        state_d = S_FETCH;
                    end else begin
                        state_d = S_WB;
                    end
                end
                S_MEM: begin
                    dmem_req = 1'b1;
                    DMWr     = is_store;
                    if (dmem_ready) begin
                        PCWr    = is_store;
                        state_d = is_store ? S_FETCH : S_WB;
                    end else if (timeout_hit) begin
                        state_d = S_TRAP;
                        cause_d = CAUSE_TIMEOUT;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                S_MDU_WAIT: begin
                    if (mdu_done) begin
                        state_d = S_WB;
                    end else if (timeout_hit) begin
                        state_d = S_TRAP;
                        cause_d = CAUSE_TIMEOUT;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                S_WB: begin
                    RUWr    = 1'b1;
                    PCWr    = 1'b1;
                    state_d = S_FETCH;
                end
                S_TRAP: begin
                    state_d = S_TRAP;
                end
                default: begin
                    state_d = S_TRAP;
                    cause_d = CAUSE_ILLEGAL;
                end
            endcase
            if (state_d != state_q) cnt_d = '0;
        end
    end

    always_comb begin
        ALUOp = 5'b00000;
        if (is_r || (is_i && (Funct3 == 3'b001 || Funct3 == 3'b101))) begin
            ALUOp[3:0] = {Funct7[5], Funct3};
        end else if (is_i) begin
            ALUOp[3:0] = {1'b0, Funct3};
        end else if (is_lui || is_auipc) begin
            ALUOp[3:0] = 4'b0111;
        end
        ALUOp[4] = is_mext;

        ImmSrc = 3'b000;
        if (is_store)                ImmSrc = 3'b001;
        else if (is_branch)          ImmSrc = 3'b101;
        else if (is_lui || is_auipc) ImmSrc = 3'b010;
        else if (is_jal)             ImmSrc = 3'b110;

        RUDataWrSrc = 2'b00;
        if (is_load)               RUDataWrSrc = 2'b01;
        else if (is_jal || is_jalr) RUDataWrSrc = 2'b10;

        BrOp = 5'b00000;
        if (state_q == S_EXEC || state_q == S_WB) BrOp = {is_jal | is_jalr, OpCode[6], Funct3};
    end

    assign ALUASrc    = OpCode[6] & ~is_jalr;
    assign ALUBSrc    = ~is_r;
    assign DMCtrl     = Funct3;
    assign trap       = (state_q == S_TRAP);
    assign trap_cause = cause_q;
    assign state      = state_q;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Directed bench for multicycle_control_unit: one MEXT-enabled and one base-ISA instance
// share the stimulus; each task checks its scenario against hand-derived values.
module tb_multicycle_control_unit;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [6:0] OpCode, Funct7;
    logic [2:0] Funct3;
    logic       imem_ready, dmem_ready, mdu_done;

    logic       imem_req_a, dmem_req_a, IRWr_a, PCWr_a, mdu_start_a, RUWr_a;
    logic [4:0] ALUOp_a, BrOp_a;
    logic [2:0] ImmSrc_a, DMCtrl_a, state_a;
    logic       ALUASrc_a, ALUBSrc_a, DMWr_a, trap_a;
    logic [1:0] RUDataWrSrc_a, trap_cause_a;

    logic       imem_req_b, dmem_req_b, IRWr_b, PCWr_b, mdu_start_b, RUWr_b;
    logic [4:0] ALUOp_b, BrOp_b;
    logic [2:0] ImmSrc_b, DMCtrl_b, state_b;
    logic       ALUASrc_b, ALUBSrc_b, DMWr_b, trap_b;
    logic [1:0] RUDataWrSrc_b, trap_cause_b;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    multicycle_control_unit #(.MEXT_EN(1), .MEM_TIMEOUT(4)) dut_a (
        .clk(clk), .rst_n(rst_n), .OpCode(OpCode), .Funct3(Funct3), .Funct7(Funct7),
        .imem_ready(imem_ready), .dmem_ready(dmem_ready), .mdu_done(mdu_done),
        .imem_req(imem_req_a), .dmem_req(dmem_req_a), .IRWr(IRWr_a), .PCWr(PCWr_a),
        .mdu_start(mdu_start_a), .RUWr(RUWr_a), .ALUOp(ALUOp_a), .ImmSrc(ImmSrc_a),
        .ALUASrc(ALUASrc_a), .ALUBSrc(ALUBSrc_a), .DMWr(DMWr_a), .DMCtrl(DMCtrl_a),
        .BrOp(BrOp_a), .RUDataWrSrc(RUDataWrSrc_a), .trap(trap_a),
        .trap_cause(trap_cause_a), .state(state_a)
    );

    multicycle_control_unit #(.MEXT_EN(0), .MEM_TIMEOUT(4)) dut_b (
        .clk(clk), .rst_n(rst_n), .OpCode(OpCode), .Funct3(Funct3), .Funct7(Funct7),
        .imem_ready(imem_ready), .dmem_ready(dmem_ready), .mdu_done(mdu_done),
        .imem_req(imem_req_b), .dmem_req(dmem_req_b), .IRWr(IRWr_b), .PCWr(PCWr_b),
        .mdu_start(mdu_start_b), .RUWr(RUWr_b), .ALUOp(ALUOp_b), .ImmSrc(ImmSrc_b),
        .ALUASrc(ALUASrc_b), .ALUBSrc(ALUBSrc_b), .DMWr(DMWr_b), .DMCtrl(DMCtrl_b),
        .BrOp(BrOp_b), .RUDataWrSrc(RUDataWrSrc_b), .trap(trap_b),
        .trap_cause(trap_cause_b), .state(state_b)
    );

    task automatic set_instr(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7);
        OpCode = op;
        Funct3 = f3;
        Funct7 = f7;
    endtask

    // Leaves both instances in FETCH, running, at a falling edge.
    task automatic do_reset();
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        imem_ready = 1'b1; dmem_ready = 1'b1; mdu_done = 1'b0;
        set_instr(7'b0110011, 3'b000, 7'b0000000);
        @(negedge clk);
        total++; if (state_a !== 3'd0) begin bad++; $display("FAIL reset_state: got %0d want 0", state_a); end
        total++; if ({trap_a, trap_cause_a} !== 3'b000) begin bad++; $display("FAIL reset_trap: got %b want 000", {trap_a, trap_cause_a}); end
        total++; if ({imem_req_a, dmem_req_a, IRWr_a, PCWr_a, RUWr_a, DMWr_a, mdu_start_a} !== 7'b0) begin
            bad++; $display("FAIL reset_enables: got %b want 0000000", {imem_req_a, dmem_req_a, IRWr_a, PCWr_a, RUWr_a, DMWr_a, mdu_start_a});
        end
        rst_n = 1'b1;
        #1;
        total++; if (imem_req_a !== 1'b0) begin bad++; $display("FAIL reset_release_req: got %b want 0", imem_req_a); end
        @(negedge clk);
        total++; if ({imem_req_a, IRWr_a} !== 2'b11) begin bad++; $display("FAIL first_fetch: got %b want 11", {imem_req_a, IRWr_a}); end
    endtask

    task automatic test_add();
        logic [2:0] exp_st [5];
        int pc = 0, ru = 0;
        exp_st = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd0};
        imem_ready = 1'b1; dmem_ready = 1'b1; mdu_done = 1'b0;
        set_instr(7'b0110011, 3'b000, 7'b0000000);
        do_reset();
        for (int i = 0; i < 5; i++) begin
            #1;
            total++; if (state_a !== exp_st[i]) begin bad++; $display("FAIL add_state[%0d]: got %0d want %0d", i, state_a, exp_st[i]); end
            if (i < 4) begin pc += int'(PCWr_a); ru += int'(RUWr_a); end
            if (i == 3) begin
                total++; if ({ALUOp_a, ALUBSrc_a} !== 6'b000000) begin bad++; $display("FAIL add_aluop: got %b want 000000", {ALUOp_a, ALUBSrc_a}); end
            end
            @(negedge clk);
        end
        total++; if (pc !== 1 || ru !== 1) begin bad++; $display("FAIL add_pulses: got pc=%0d ru=%0d want 1 1", pc, ru); end
    endtask

    task automatic test_lw();
        logic [2:0] exp_st [9];
        int pc = 0, ru = 0;
        exp_st = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd3, 3'd3, 3'd3, 3'd4, 3'd0};
        imem_ready = 1'b1; dmem_ready = 1'b0;
        set_instr(7'b0000011, 3'b010, 7'b0000000);
        do_reset();
        for (int i = 0; i < 9; i++) begin
            dmem_ready = (i == 6);
            #1;
            total++; if (state_a !== exp_st[i]) begin bad++; $display("FAIL lw_state[%0d]: got %0d want %0d", i, state_a, exp_st[i]); end
            if (exp_st[i] == 3'd3) begin
                total++; if (dmem_req_a !== 1'b1) begin bad++; $display("FAIL lw_dmem_req[%0d]: got %b want 1", i, dmem_req_a); end
            end
            if (i == 7) begin
                total++; if (RUDataWrSrc_a !== 2'b01) begin bad++; $display("FAIL lw_wrsrc: got %b want 01", RUDataWrSrc_a); end
            end
            if (i < 8) begin pc += int'(PCWr_a); ru += int'(RUWr_a); end
            @(negedge clk);
        end
        total++; if (pc !== 1 || ru !== 1) begin bad++; $display("FAIL lw_pulses: got pc=%0d ru=%0d want 1 1", pc, ru); end
        dmem_ready = 1'b0;
    endtask

    task automatic test_sw();
        logic [2:0] exp_st [6];
        int ru = 0;
        exp_st = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd3, 3'd0};
        imem_ready = 1'b1; dmem_ready = 1'b0;
        set_instr(7'b0100011, 3'b010, 7'b0000000);
        do_reset();
        for (int i = 0; i < 6; i++) begin
            dmem_ready = (i == 4);
            #1;
            total++; if (state_a !== exp_st[i]) begin bad++; $display("FAIL sw_state[%0d]: got %0d want %0d", i, state_a, exp_st[i]); end
            total++; if (DMWr_a !== (exp_st[i] == 3'd3)) begin bad++; $display("FAIL sw_dmwr[%0d]: got %b want %b", i, DMWr_a, exp_st[i] == 3'd3); end
            if (i < 5) begin
                total++; if (PCWr_a !== (i == 4)) begin bad++; $display("FAIL sw_pcwr[%0d]: got %b want %b", i, PCWr_a, i == 4); end
                ru += int'(RUWr_a);
            end
            @(negedge clk);
        end
        total++; if (ru !== 0) begin bad++; $display("FAIL sw_ruwr: got %0d want 0", ru); end
        dmem_ready = 1'b0;
    endtask

    task automatic test_beq();
        logic [2:0] exp_st [4];
        int pc = 0;
        exp_st = '{3'd0, 3'd1, 3'd2, 3'd0};
        imem_ready = 1'b1;
        set_instr(7'b1100011, 3'b000, 7'b0000000);
        do_reset();
        for (int i = 0; i < 4; i++) begin
            #1;
            total++; if (state_a !== exp_st[i]) begin bad++; $display("FAIL beq_state[%0d]: got %0d want %0d", i, state_a, exp_st[i]); end
            if (i == 0) begin
                total++; if (BrOp_a !== 5'b00000) begin bad++; $display("FAIL beq_brop_fetch: got %b want 00000", BrOp_a); end
            end
            if (i == 2) begin
                total++; if ({PCWr_a, BrOp_a, ImmSrc_a} !== {1'b1, 5'b01000, 3'b101}) begin
                    bad++; $display("FAIL beq_exec: got pcwr=%b brop=%b imm=%b want 1 01000 101", PCWr_a, BrOp_a, ImmSrc_a);
                end
            end
            if (i < 3) pc += int'(PCWr_a);
            @(negedge clk);
        end
        total++; if (pc !== 1) begin bad++; $display("FAIL beq_pcwr_count: got %0d want 1", pc); end
    endtask

    task automatic test_jal();
        logic [2:0] exp_st [5];
        int pc = 0;
        exp_st = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd0};
        imem_ready = 1'b1;
        set_instr(7'b1101111, 3'b011, 7'b0000000);
        do_reset();
        for (int i = 0; i < 5; i++) begin
            #1;
            total++; if (state_a !== exp_st[i]) begin bad++; $display("FAIL jal_state[%0d]: got %0d want %0d", i, state_a, exp_st[i]); end
            if (i == 3) begin
                total++; if ({RUDataWrSrc_a, BrOp_a[4:3], ImmSrc_a, RUWr_a} !== {2'b10, 2'b11, 3'b110, 1'b1}) begin
                    bad++; $display("FAIL jal_wb: got src=%b brop=%b imm=%b ruwr=%b want 10 11xxx 110 1", RUDataWrSrc_a, BrOp_a, ImmSrc_a, RUWr_a);
                end
            end
            if (i < 4) pc += int'(PCWr_a);
            @(negedge clk);
        end
        total++; if (pc !== 1) begin bad++; $display("FAIL jal_pcwr_count: got %0d want 1", pc); end
    endtask

    task automatic test_mext();
        logic [2:0] exp_a [7];
        logic [2:0] exp_b [7];
        int starts = 0;
        exp_a = '{3'd0, 3'd1, 3'd5, 3'd5, 3'd5, 3'd4, 3'd0};
        exp_b = '{3'd0, 3'd1, 3'd6, 3'd6, 3'd6, 3'd6, 3'd6};
        imem_ready = 1'b1; mdu_done = 1'b0;
        set_instr(7'b0110011, 3'b000, 7'b0000001);
        do_reset();
        for (int i = 0; i < 7; i++) begin
            mdu_done = (i == 4);
            #1;
            total++; if (state_a !== exp_a[i]) begin bad++; $display("FAIL mext_state[%0d]: got %0d want %0d", i, state_a, exp_a[i]); end
            total++; if (state_b !== exp_b[i]) begin bad++; $display("FAIL m_illegal_state[%0d]: got %0d want %0d", i, state_b, exp_b[i]); end
            if (i == 1) begin
                total++; if ({mdu_start_a, ALUOp_a[4], mdu_start_b, ALUOp_b[4]} !== 4'b1100) begin
                    bad++; $display("FAIL mext_start: got %b want 1100", {mdu_start_a, ALUOp_a[4], mdu_start_b, ALUOp_b[4]});
                end
            end
            if (i >= 2) begin
                total++; if ({trap_b, trap_cause_b, imem_req_b} !== 4'b1010) begin
                    bad++; $display("FAIL m_illegal_trap[%0d]: got %b want 1010", i, {trap_b, trap_cause_b, imem_req_b});
                end
            end
            starts += int'(mdu_start_a);
            @(negedge clk);
        end
        total++; if (starts !== 1) begin bad++; $display("FAIL mext_start_count: got %0d want 1", starts); end
        mdu_done = 1'b0;
    endtask

    task automatic test_illegal_opcode();
        imem_ready = 1'b1;
        set_instr(7'b1111111, 3'b000, 7'b0000000);
        do_reset();
        @(negedge clk);
        @(negedge clk);
        #1;
        total++; if ({state_a, trap_a, trap_cause_a} !== {3'd6, 1'b1, 2'b01}) begin
            bad++; $display("FAIL illegal_opcode: got state=%0d trap=%b cause=%b want 6 1 01", state_a, trap_a, trap_cause_a);
        end
    endtask

    task automatic test_timeout();
        imem_ready = 1'b0;
        set_instr(7'b0110011, 3'b000, 7'b0000000);
        do_reset();
        for (int i = 0; i < 4; i++) begin
            #1;
            total++; if ({state_a, imem_req_a} !== {3'd0, 1'b1}) begin bad++; $display("FAIL timeout_wait[%0d]: got state=%0d req=%b want 0 1", i, state_a, imem_req_a); end
            @(negedge clk);
        end
        #1;
        total++; if ({state_a, trap_a, trap_cause_a, imem_req_a} !== {3'd6, 1'b1, 2'b10, 1'b0}) begin
            bad++; $display("FAIL timeout_trap: got state=%0d trap=%b cause=%b req=%b want 6 1 10 0", state_a, trap_a, trap_cause_a, imem_req_a);
        end
        imem_ready = 1'b1;
        @(negedge clk);
        #1;
        total++; if ({state_a, trap_cause_a} !== {3'd6, 2'b10}) begin bad++; $display("FAIL trap_absorbing: got state=%0d cause=%b want 6 10", state_a, trap_cause_a); end
        imem_ready = 1'b0;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            imem_ready = (i == 3);
            #1;
            @(negedge clk);
        end
        #1;
        total++; if ({state_a, trap_a} !== {3'd1, 1'b0}) begin bad++; $display("FAIL timeout_ready_wins: got state=%0d trap=%b want 1 0", state_a, trap_a); end
    endtask

    task automatic test_reset_mid_store();
        imem_ready = 1'b1; dmem_ready = 1'b0;
        set_instr(7'b0100011, 3'b010, 7'b0000000);
        do_reset();
        @(negedge clk); @(negedge clk); @(negedge clk);
        #1;
        total++; if ({state_a, DMWr_a} !== {3'd3, 1'b1}) begin bad++; $display("FAIL rst_store_setup: got state=%0d dmwr=%b want 3 1", state_a, DMWr_a); end
        #2 rst_n = 1'b0;
        #1;
        total++; if ({state_a, DMWr_a, dmem_req_a, PCWr_a, RUWr_a} !== {3'd0, 4'b0000}) begin
            bad++; $display("FAIL rst_store_drop: got state=%0d dmwr=%b req=%b pcwr=%b ruwr=%b want 0 0 0 0 0", state_a, DMWr_a, dmem_req_a, PCWr_a, RUWr_a);
        end
        @(posedge clk);
        #1;
        total++; if ({PCWr_a, RUWr_a, imem_req_a} !== 3'b000) begin bad++; $display("FAIL rst_store_hold: got %b want 000", {PCWr_a, RUWr_a, imem_req_a}); end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        total++; if (imem_req_a !== 1'b0) begin bad++; $display("FAIL rst_store_release: got %b want 0", imem_req_a); end
        @(negedge clk);
        total++; if ({state_a, imem_req_a} !== {3'd0, 1'b1}) begin bad++; $display("FAIL rst_store_refetch: got state=%0d req=%b want 0 1", state_a, imem_req_a); end
    endtask

    task automatic test_decode();
        set_instr(7'b0010011, 3'b101, 7'b0100000);
        #1;
        total++; if ({ALUOp_a, ALUBSrc_a, ImmSrc_a} !== {5'b01101, 1'b1, 3'b000}) begin
            bad++; $display("FAIL dec_srai: got alu=%b bsrc=%b imm=%b want 01101 1 000", ALUOp_a, ALUBSrc_a, ImmSrc_a);
        end
        set_instr(7'b0010011, 3'b000, 7'b0100000);
        #1;
        total++; if (ALUOp_a !== 5'b00000) begin bad++; $display("FAIL dec_addi: got %b want 00000", ALUOp_a); end
        set_instr(7'b0110011, 3'b000, 7'b0100000);
        #1;
        total++; if (ALUOp_a !== 5'b01000) begin bad++; $display("FAIL dec_sub: got %b want 01000", ALUOp_a); end
        set_instr(7'b0110111, 3'b000, 7'b0000000);
        #1;
        total++; if ({ALUOp_a, ImmSrc_a, ALUASrc_a} !== {5'b00111, 3'b010, 1'b0}) begin
            bad++; $display("FAIL dec_lui: got alu=%b imm=%b asrc=%b want 00111 010 0", ALUOp_a, ImmSrc_a, ALUASrc_a);
        end
        set_instr(7'b1100111, 3'b000, 7'b0000000);
        #1;
        total++; if ({ALUASrc_a, RUDataWrSrc_a, ImmSrc_a} !== {1'b0, 2'b10, 3'b000}) begin
            bad++; $display("FAIL dec_jalr: got asrc=%b src=%b imm=%b want 0 10 000", ALUASrc_a, RUDataWrSrc_a, ImmSrc_a);
        end
        set_instr(7'b0000011, 3'b100, 7'b0000000);
        #1;
        total++; if ({DMCtrl_a, ImmSrc_a, ALUBSrc_a} !== {3'b100, 3'b000, 1'b1}) begin
            bad++; $display("FAIL dec_lbu: got dmctrl=%b imm=%b bsrc=%b want 100 000 1", DMCtrl_a, ImmSrc_a, ALUBSrc_a);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_add();
        test_lw();
        test_sw();
        test_beq();
        test_jal();
        test_mext();
        test_illegal_opcode();
        test_timeout();
        test_reset_mid_store();
        test_decode();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
